// File: rtl/cache_mem_arbiter.sv
// Shares one burst memory port between icache and dcache, holding each grant for a full line burst.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed dcache priority.
module cache_mem_arbiter #(
  parameter int BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_wlast,
  input  logic        d_awvalid,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wlast,
  output logic        mem_awvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;

  state_t state, state_next;
  logic [BEAT_W-1:0] beat, beat_next;
  logic grant_d;
  logic burst_end;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {ICACHE, DCACHE} owner_t;
  owner_t last_grant;

  assign grant_d = d_req && (!i_req || (last_grant == ICACHE));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= ICACHE;
    end else if (burst_end) begin
      last_grant <= (state == I_RD) ? ICACHE : DCACHE;
    end
  end
`else
  assign grant_d = d_req;
`endif

  // Writes end on the owner's last-beat marker; reads end on the beat count.
  always_comb begin
    burst_end = 1'b0;
    if (mem_data_ok) begin
      unique case (state)
        I_RD, D_RD: burst_end = (beat == LAST_BEAT);
        D_WR:       burst_end = d_wlast;
        default:    burst_end = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  always_comb begin
    state_next = state;
    beat_next  = beat;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = d_wen ? D_WR : D_RD;
        end else if (i_req) begin
          state_next = I_RD;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (burst_end) begin
          state_next = IDLE;
          beat_next  = '0;
        end else if (mem_data_ok) begin
          beat_next = beat + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory side follows the owner only; everything stays quiet while reset is held.
  always_comb begin
    mem_req     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wlast   = 1'b0;
    mem_awvalid = 1'b0;
    i_addr_ok   = 1'b0;
    i_data_ok   = 1'b0;
    d_addr_ok   = 1'b0;
    d_data_ok   = 1'b0;
    if (!reset) begin
      unique case (state)
        I_RD: begin
          mem_req   = i_req;
          mem_addr  = i_addr;
          i_addr_ok = mem_addr_ok;
          i_data_ok = mem_data_ok;
        end
        D_RD: begin
          mem_req   = d_req;
          mem_addr  = d_addr;
          d_addr_ok = mem_addr_ok;
          d_data_ok = mem_data_ok;
        end
        D_WR: begin
          mem_req     = d_req;
          mem_wen     = 1'b1;
          mem_addr    = d_addr;
          mem_wdata   = d_wdata;
          mem_wlast   = d_wlast;
          mem_awvalid = d_awvalid;
          d_addr_ok   = mem_addr_ok;
          d_data_ok   = mem_data_ok;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Table-driven bench for cache_mem_arbiter; each row gives inputs and the owner expected in that cycle.
// Honors ARB_ROUND_ROBIN_EN for the back-to-back contention expectation.
module tb_cache_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef enum logic [1:0] {O_NONE, O_I, O_D, O_W} own_e;

  typedef struct {
    logic rst;
    logic ireq;
    logic dreq;
    logic dwen;
    logic dwlast;
    logic awv;
    logic aok;
    logic dok;
    own_e own;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_wlast;
  logic        d_awvalid;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wlast;
  logic        mem_awvalid;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  cache_mem_arbiter #(.BURST_LEN(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_wlast(d_wlast),
    .d_awvalid(d_awvalid), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wlast(mem_wlast), .mem_awvalid(mem_awvalid), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add_n(input int n, input logic rst, ireq, dreq, dwen, dwlast, awv, aok, dok,
                                input own_e own);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.dwen = dwen; v.dwlast = dwlast;
    v.awv = awv; v.aok = aok; v.dok = dok; v.own = own;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic compare(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    reset       = v.rst;
    i_req       = v.ireq;
    d_req       = v.dreq;
    d_wen       = v.dwen;
    d_wlast     = v.dwlast;
    d_awvalid   = v.awv;
    mem_addr_ok = v.aok;
    mem_data_ok = v.dok;
    i_addr      = 32'h1000_0000 + 32'(idx * 4);
    d_addr      = 32'h2000_0000 + 32'(idx * 4);
    d_wdata     = 32'hC0DE_0000 ^ 32'(idx);
    mem_rdata   = 32'h5A5A_0000 + 32'(idx);
  endtask

  task automatic checkOutput(input int idx);
    vec_t v;
    logic [7:0]  exp_ctrl, act_ctrl;
    logic [31:0] exp_addr, exp_wdata;
    logic        e_req, e_wen, e_wlast, e_awv, e_iaok, e_idok, e_daok, e_ddok;
    v = vecs[idx];
    {e_req, e_wen, e_wlast, e_awv, e_iaok, e_idok, e_daok, e_ddok} = '0;
    exp_addr  = '0;
    exp_wdata = '0;
    case (v.own)
      O_I: begin
        e_req = v.ireq; e_iaok = v.aok; e_idok = v.dok; exp_addr = i_addr;
      end
      O_D: begin
        e_req = v.dreq; e_daok = v.aok; e_ddok = v.dok; exp_addr = d_addr;
      end
      O_W: begin
        e_req = v.dreq; e_daok = v.aok; e_ddok = v.dok; exp_addr = d_addr;
        e_wen = 1'b1; e_wlast = v.dwlast; e_awv = v.awv; exp_wdata = d_wdata;
      end
      default: e_req = 1'b0;
    endcase
    exp_ctrl = {e_req, e_wen, e_wlast, e_awv, e_iaok, e_idok, e_daok, e_ddok};
    act_ctrl = {mem_req, mem_wen, mem_wlast, mem_awvalid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok};
    compare($sformatf("vec%0d_ctrl", idx), 128'(act_ctrl), 128'(exp_ctrl));
    compare($sformatf("vec%0d_data", idx), {mem_addr, mem_wdata, i_rdata, d_rdata},
            {exp_addr, exp_wdata, mem_rdata, mem_rdata});
  endtask

  initial begin
    int lat;
    bit got;

    // rst ireq dreq dwen dwlast awv aok dok owner
    add_n(2, 1, 1, 1, 0, 0, 0, 1, 1, O_NONE);
    // dcache refill alone
    add_n(1, 0, 0, 1, 0, 0, 0, 0, 0, O_NONE);
    add_n(1, 0, 0, 1, 0, 0, 0, 1, 0, O_D);
    add_n(8, 0, 0, 1, 0, 0, 0, 0, 1, O_D);
    add_n(1, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    // write-back: d_wen drops mid-burst, a stall beat, wlast without data_ok
    add_n(1, 0, 0, 1, 1, 0, 1, 0, 0, O_NONE);
    add_n(1, 0, 0, 1, 1, 0, 1, 1, 0, O_W);
    add_n(3, 0, 0, 1, 1, 0, 0, 0, 1, O_W);
    add_n(1, 0, 0, 1, 0, 0, 0, 0, 0, O_W);
    add_n(4, 0, 0, 1, 0, 0, 0, 0, 1, O_W);
    add_n(1, 0, 0, 1, 0, 1, 0, 0, 0, O_W);
    add_n(1, 0, 0, 1, 0, 1, 0, 0, 1, O_W);
    add_n(1, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    // contention after reset: D, I, D, then RR ? I : D
    add_n(1, 1, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    add_n(1, 0, 1, 1, 0, 0, 0, 0, 0, O_NONE);
    add_n(8, 0, 1, 1, 0, 0, 0, 1, 1, O_D);
    add_n(1, 0, 1, 0, 0, 0, 0, 0, 0, O_NONE);
    add_n(8, 0, 1, 0, 0, 0, 0, 1, 1, O_I);
    add_n(1, 0, 1, 1, 0, 0, 0, 0, 0, O_NONE);
    add_n(8, 0, 1, 1, 0, 0, 0, 0, 1, O_D);
    add_n(1, 0, 1, 1, 0, 0, 0, 0, 0, O_NONE);
    add_n(8, 0, 1, 1, 0, 0, 0, 0, 1, RR ? O_I : O_D);
    add_n(1, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    // icache drops req after beat 3 while dcache waits
    add_n(1, 0, 1, 0, 0, 0, 0, 0, 0, O_NONE);
    add_n(4, 0, 1, 0, 0, 0, 0, 0, 1, O_I);
    add_n(2, 0, 0, 1, 0, 0, 0, 1, 0, O_I);
    add_n(4, 0, 1, 1, 0, 0, 0, 0, 1, O_I);
    add_n(1, 0, 0, 1, 0, 0, 0, 0, 0, O_NONE);
    add_n(1, 0, 0, 1, 0, 0, 0, 1, 0, O_D);
    add_n(5, 0, 0, 1, 0, 0, 0, 0, 1, O_D);
    // reset at beat 5, then a full icache burst proves beat restarted at 0
    add_n(1, 1, 0, 1, 0, 0, 0, 0, 1, O_NONE);
    add_n(1, 0, 1, 0, 0, 0, 0, 0, 0, O_NONE);
    add_n(8, 0, 1, 0, 0, 0, 0, 0, 1, O_I);
    add_n(1, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(i);
      #1;
      checkOutput(i);
    end

    // Hand-written: grant latency and single idle cycle between bursts
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0; d_wen = 1'b0; mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    i_req = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 4) begin
      #1;
      if (mem_req) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    compare("grant_latency", 128'(got ? lat : 99), 128'(1));

    for (int k = 0; k < 8; k++) begin
      mem_data_ok = 1'b1;
      @(negedge clk);
    end
    mem_data_ok = 1'b0;
    #1;
    compare("idle_after_burst", 128'(mem_req), 128'(0));
    @(negedge clk);
    #1;
    compare("regrant_after_idle", 128'({mem_req, i_addr_ok, d_addr_ok}), 128'(3'b100));
    i_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
